// File: rtl/pipe_id_exe_issue_if.sv
// ID/EXE issue bundle: decoded ID fields, EXE/MEM forwarding taps,
// registered EXE operands, IF/ID write enable and performance counters.
interface pipe_id_exe_issue_if #(
  parameter int CNT_W = 32
);
  // ID stage inputs
  logic [4:0]       drs, drt, drn;
  logic             duse_rs, duse_rt;
  logic [31:0]      qa, qb, dimm, dpc4;
  logic [3:0]       daluc;
  logic             daluimm, dshift, djal, dwreg, dm2reg, dwmem;
  logic             flush;
  // EXE / MEM forwarding taps
  logic [4:0]       ern, mrn;
  logic [31:0]      ealu, malu, mmo;
  logic             mwreg, mm2reg;
  // Registered EXE bundle
  logic [31:0]      ea, eb, eimm, epc4;
  logic [3:0]       ealuc;
  logic [4:0]       ern0;
  logic             ealuimm, eshift, ejal, ewreg, em2reg, ewmem;
  // Hazard / statistics
  logic             wpcir;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Producer side (ID stage, pipeline taps) drives decoded fields, consumes EXE bundle
  modport master (
    output drs, drt, drn, duse_rs, duse_rt, qa, qb, dimm, dpc4, daluc,
           daluimm, dshift, djal, dwreg, dm2reg, dwmem, flush,
           ern, mrn, ealu, malu, mmo, mwreg, mm2reg,
    input  ea, eb, eimm, epc4, ealuc, ern0, ealuimm, eshift, ejal, ewreg,
           em2reg, ewmem, wpcir, stall_cnt, flush_cnt
  );

  // Issue stage side
  modport slave (
    input  drs, drt, drn, duse_rs, duse_rt, qa, qb, dimm, dpc4, daluc,
           daluimm, dshift, djal, dwreg, dm2reg, dwmem, flush,
           ern, mrn, ealu, malu, mmo, mwreg, mm2reg,
    output ea, eb, eimm, epc4, ealuc, ern0, ealuimm, eshift, ejal, ewreg,
           em2reg, ewmem, wpcir, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_id_exe_issue.sv
// ID->EXE issue stage: ID/EXE pipeline register with EXE/MEM operand
// forwarding, load-use hazard detection (bubble + IF/ID stall), and
// saturating stall/flush counters.
module pipe_id_exe_issue #(
  parameter int CNT_W = 32
) (
  input logic               clock,
  input logic               reset,
  pipe_id_exe_issue_if.slave bus
);

  logic [31:0]      ea_q, ea_d, eb_q, eb_d, eimm_q, eimm_d, epc4_q, epc4_d;
  logic [3:0]       ealuc_q, ealuc_d;
  logic [4:0]       ern0_q, ern0_d;
  logic             ealuimm_q, ealuimm_d, eshift_q, eshift_d, ejal_q, ejal_d;
  logic             ewreg_q, ewreg_d, em2reg_q, em2reg_d, ewmem_q, ewmem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [1:0][4:0]  src_sel;
  logic [1:0][31:0] rf_val;
  logic [1:0][31:0] fwd_val;
  logic             stall;

  assign src_sel[0] = bus.drs;
  assign src_sel[1] = bus.drt;
  assign rf_val[0]  = bus.qa;
  assign rf_val[1]  = bus.qb;

  // Per-operand forwarding: the EXE ALU result is newest, then MEM (load data
  // or ALU result), else the register file. r0 is never forwarded. A load in
  // EXE cannot forward yet; that case is caught by the stall logic.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic hit_e, hit_m;
    assign hit_e = ewreg_q & ~em2reg_q & (bus.ern != 5'd0) & (bus.ern == src_sel[gi]);
    assign hit_m = bus.mwreg & (bus.mrn != 5'd0) & (bus.mrn == src_sel[gi]);
    assign fwd_val[gi] = hit_e ? bus.ealu :
                         hit_m ? (bus.mm2reg ? bus.mmo : bus.malu) :
                         rf_val[gi];
  end

  // Load in EXE whose destination is read by the ID instruction
  assign stall = ewreg_q & em2reg_q & (bus.ern != 5'd0) &
                 ((bus.duse_rs & (bus.ern == bus.drs)) |
                  (bus.duse_rt & (bus.ern == bus.drt)));

  // Next-state: flush beats stall beats normal issue; bubbles zero everything
  always_comb begin
    ea_d        = '0;
    eb_d        = '0;
    eimm_d      = '0;
    epc4_d      = '0;
    ealuc_d     = '0;
    ern0_d      = '0;
    ealuimm_d   = 1'b0;
    eshift_d    = 1'b0;
    ejal_d      = 1'b0;
    ewreg_d     = 1'b0;
    em2reg_d    = 1'b0;
    ewmem_d     = 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      ea_d      = fwd_val[0];
      eb_d      = fwd_val[1];
      eimm_d    = bus.dimm;
      epc4_d    = bus.dpc4;
      ealuc_d   = bus.daluc;
      ern0_d    = bus.drn;
      ealuimm_d = bus.daluimm;
      eshift_d  = bus.dshift;
      ejal_d    = bus.djal;
      ewreg_d   = bus.dwreg;
      em2reg_d  = bus.dm2reg;
      ewmem_d   = bus.dwmem;
    end
  end

  // ID/EXE pipeline register and counters, cleared immediately on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ea_q        <= '0;
      eb_q        <= '0;
      eimm_q      <= '0;
      epc4_q      <= '0;
      ealuc_q     <= '0;
      ern0_q      <= '0;
      ealuimm_q   <= 1'b0;
      eshift_q    <= 1'b0;
      ejal_q      <= 1'b0;
      ewreg_q     <= 1'b0;
      em2reg_q    <= 1'b0;
      ewmem_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      eimm_q      <= eimm_d;
      epc4_q      <= epc4_d;
      ealuc_q     <= ealuc_d;
      ern0_q      <= ern0_d;
      ealuimm_q   <= ealuimm_d;
      eshift_q    <= eshift_d;
      ejal_q      <= ejal_d;
      ewreg_q     <= ewreg_d;
      em2reg_q    <= em2reg_d;
      ewmem_q     <= ewmem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ea        = ea_q;
  assign bus.eb        = eb_q;
  assign bus.eimm      = eimm_q;
  assign bus.epc4      = epc4_q;
  assign bus.ealuc     = ealuc_q;
  assign bus.ern0      = ern0_q;
  assign bus.ealuimm   = ealuimm_q;
  assign bus.eshift    = eshift_q;
  assign bus.ejal      = ejal_q;
  assign bus.ewreg     = ewreg_q;
  assign bus.em2reg    = em2reg_q;
  assign bus.ewmem     = ewmem_q;
  assign bus.wpcir     = ~stall;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_id_exe_issue.sv
// Scoreboard bench for pipe_id_exe_issue: expected EXE bundles are queued as
// each ID instruction is driven and popped when the next edge produces them.
module tb_pipe_id_exe_issue;
  localparam int CW = 4;  // narrow counters so saturation is reachable

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_id_exe_issue_if #(.CNT_W(CW)) bus ();
  pipe_id_exe_issue #(.CNT_W(CW)) dut (.clock(clk), .reset(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] ea, eb, eimm, epc4;
    logic [3:0]  aluc;
    logic [4:0]  rn;
    logic [5:0]  ctrl;  // {aluimm, shift, jal, wreg, m2reg, wmem}
  } bundle_t;

  bundle_t exp_q[$];
  bundle_t got, want;
  int n_cmp = 0;
  int n_err = 0;

  function automatic bundle_t mk(logic [31:0] a, b, imm, pc4, logic [3:0] aluc,
                                 logic [4:0] rn, logic [5:0] c);
    mk = {a, b, imm, pc4, aluc, rn, c};
  endfunction

  function automatic bundle_t obs();
    obs = {bus.ea, bus.eb, bus.eimm, bus.epc4, bus.ealuc, bus.ern0, bus.ealuimm,
           bus.eshift, bus.ejal, bus.ewreg, bus.em2reg, bus.ewmem};
  endfunction

  task automatic set_id(input logic [4:0] rs, rt, input logic urs, urt,
                        input logic [31:0] a, b, imm, pc4, input logic [4:0] rn,
                        input logic [3:0] aluc, input logic [5:0] c);
    bus.drs = rs; bus.drt = rt; bus.duse_rs = urs; bus.duse_rt = urt;
    bus.qa = a; bus.qb = b; bus.dimm = imm; bus.dpc4 = pc4; bus.drn = rn;
    bus.daluc = aluc;
    {bus.daluimm, bus.dshift, bus.djal, bus.dwreg, bus.dm2reg, bus.dwmem} = c;
  endtask

  task automatic set_fwd(input logic [4:0] ern, input logic [31:0] ealu,
                         input logic mwreg, mm2reg, input logic [4:0] mrn,
                         input logic [31:0] malu, mmo);
    bus.ern = ern; bus.ealu = ealu; bus.mwreg = mwreg; bus.mm2reg = mm2reg;
    bus.mrn = mrn; bus.malu = malu; bus.mmo = mmo;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_cmp++; if (obs() !== '0) begin n_err++; $display("FAIL reset_bundle: got %h want 0", obs()); end
    n_cmp++; if (bus.wpcir !== 1'b1) begin n_err++; $display("FAIL reset_wpcir: got %b want 1", bus.wpcir); end
    n_cmp++; if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
      n_err++; $display("FAIL reset_cnt: got %h/%h want 0/0", bus.stall_cnt, bus.flush_cnt); end
    rst = 1'b0;
    // load issued, then a dependent instruction; reset lands mid-stall
    set_id(1, 2, 1, 1, 32'h11, 32'h22, 32'hFFFC, 32'h0040_0004, 8, 4'h2, 6'b000110);
    exp_q.push_back(mk(32'h11, 32'h22, 32'hFFFC, 32'h0040_0004, 4'h2, 8, 6'b000110));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_load_issue: got %h want %h", got, want); end
    set_fwd(8, 0, 0, 0, 0, 0, 0);
    set_id(8, 3, 1, 0, 32'h1, 32'h2, 0, 0, 9, 0, 6'b000100);
    #1;
    n_cmp++; if (bus.wpcir !== 1'b0) begin n_err++; $display("FAIL reset_pre_stall: got wpcir=%b want 0", bus.wpcir); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (obs() !== '0) begin n_err++; $display("FAIL reset_async_bundle: got %h want 0", obs()); end
    n_cmp++; if (bus.wpcir !== 1'b1) begin n_err++; $display("FAIL reset_async_wpcir: got %b want 1", bus.wpcir); end
    n_cmp++; if (bus.stall_cnt !== '0) begin n_err++; $display("FAIL reset_async_cnt: got %h want 0", bus.stall_cnt); end
    #1 rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_exe_fwd();
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 32'h1, 32'h2, 0, 32'h0040_0008, 5, 4'h1, 6'b111100);
    exp_q.push_back(mk(32'h1, 32'h2, 0, 32'h0040_0008, 4'h1, 5, 6'b111100));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL exe_producer: got %h want %h", got, want); end
    set_fwd(5, 32'h1234, 0, 0, 0, 0, 0);
    set_id(5, 6, 1, 1, 32'hDEAD, 32'h66, 32'h10, 32'h0040_000C, 9, 4'h3, 6'b000100);
    exp_q.push_back(mk(32'h1234, 32'h66, 32'h10, 32'h0040_000C, 4'h3, 9, 6'b000100));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL exe_fwd_rs: got %h want %h", got, want); end
    set_fwd(0, 32'h4321, 0, 0, 0, 0, 0);
    set_id(0, 6, 1, 1, 32'hDEAD, 32'h77, 0, 32'h0040_0010, 10, 4'h0, 6'b000100);
    exp_q.push_back(mk(32'hDEAD, 32'h77, 0, 32'h0040_0010, 4'h0, 10, 6'b000100));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL exe_fwd_r0: got %h want %h", got, want); end
    $display("test_exe_fwd done");
  endtask

  task automatic test_mem_fwd();
    set_fwd(0, 0, 1, 1, 7, 32'h1111, 32'hAAAA_0000);
    set_id(1, 7, 1, 1, 32'h5, 32'hBBBB, 0, 32'h0040_0014, 11, 4'h4, 6'b000100);
    exp_q.push_back(mk(32'h5, 32'hAAAA_0000, 0, 32'h0040_0014, 4'h4, 11, 6'b000100));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL mem_fwd_load: got %h want %h", got, want); end
    set_fwd(0, 0, 1, 0, 7, 32'h1111, 32'hAAAA_0000);
    set_id(7, 7, 1, 1, 32'h5, 32'hBBBB, 0, 32'h0040_0018, 12, 4'h4, 6'b000100);
    exp_q.push_back(mk(32'h1111, 32'h1111, 0, 32'h0040_0018, 4'h4, 12, 6'b000100));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL mem_fwd_alu: got %h want %h", got, want); end
    set_fwd(7, 32'h55, 1, 1, 7, 32'h1111, 32'hAAAA_0000);
    set_id(0, 7, 1, 1, 32'h5, 32'hBBBB, 0, 32'h0040_001C, 13, 4'h4, 6'b000100);
    #1;
    n_cmp++; if (bus.wpcir !== 1'b1) begin n_err++; $display("FAIL mem_prio_wpcir: got %b want 1", bus.wpcir); end
    exp_q.push_back(mk(32'h5, 32'h55, 0, 32'h0040_001C, 4'h4, 13, 6'b000100));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL mem_exe_priority: got %h want %h", got, want); end
    set_fwd(0, 0, 1, 0, 0, 32'h1111, 32'hAAAA_0000);
    set_id(0, 0, 1, 1, 32'h5, 32'hBBBB, 0, 32'h0040_0020, 14, 4'h4, 6'b000100);
    exp_q.push_back(mk(32'h5, 32'hBBBB, 0, 32'h0040_0020, 4'h4, 14, 6'b000100));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL mem_fwd_r0: got %h want %h", got, want); end
    $display("test_mem_fwd done");
  endtask

  task automatic test_load_use();
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_id(2, 3, 1, 1, 32'h20, 32'h30, 32'h4, 32'h0040_0024, 8, 4'h0, 6'b000110);
    exp_q.push_back(mk(32'h20, 32'h30, 32'h4, 32'h0040_0024, 4'h0, 8, 6'b000110));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL lu_load_issue: got %h want %h", got, want); end
    set_fwd(8, 32'h777, 0, 0, 0, 0, 0);
    set_id(8, 4, 1, 1, 32'h0BAD, 32'h40, 0, 32'h0040_0028, 10, 4'h5, 6'b000100);
    #1;
    n_cmp++; if (bus.wpcir !== 1'b0) begin n_err++; $display("FAIL lu_wpcir: got %b want 0", bus.wpcir); end
    exp_q.push_back('0);
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL lu_bubble: got %h want %h", got, want); end
    n_cmp++; if (bus.stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); end
    n_cmp++; if (bus.wpcir !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b want 1", bus.wpcir); end
    // load now in MEM; ID instruction held, EXE holds the bubble
    set_fwd(0, 32'h777, 1, 1, 8, 32'h888, 32'h99);
    exp_q.push_back(mk(32'h99, 32'h40, 0, 32'h0040_0028, 4'h5, 10, 6'b000100));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL lu_mem_fwd: got %h want %h", got, want); end
    n_cmp++; if (bus.stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_stall_hold: got %0d want 1", bus.stall_cnt); end
    $display("test_load_use done");
  endtask

  task automatic test_no_false_stall();
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 32'h1, 32'h2, 0, 0, 8, 4'h0, 6'b000110);
    exp_q.push_back(mk(32'h1, 32'h2, 0, 0, 4'h0, 8, 6'b000110));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL nfs_load_issue: got %h want %h", got, want); end
    set_fwd(8, 32'h777, 0, 0, 0, 0, 0);
    set_id(8, 8, 0, 0, 32'h3, 32'h44, 0, 32'h0040_0030, 0, 4'h0, 6'b000001);
    #1;
    n_cmp++; if (bus.wpcir !== 1'b1) begin n_err++; $display("FAIL nfs_wpcir: got %b want 1", bus.wpcir); end
    exp_q.push_back(mk(32'h3, 32'h44, 0, 32'h0040_0030, 4'h0, 0, 6'b000001));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL nfs_issue: got %h want %h", got, want); end
    n_cmp++; if (bus.stall_cnt !== 4'd1) begin n_err++; $display("FAIL nfs_stall_cnt: got %0d want 1", bus.stall_cnt); end
    $display("test_no_false_stall done");
  endtask

  task automatic test_flush_stall();
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 32'h9, 32'hA, 0, 0, 8, 4'h0, 6'b000110);
    exp_q.push_back(mk(32'h9, 32'hA, 0, 0, 4'h0, 8, 6'b000110));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL fs_load_issue: got %h want %h", got, want); end
    set_fwd(8, 0, 0, 0, 0, 0, 0);
    set_id(8, 0, 1, 0, 32'h5, 32'h6, 32'h7, 32'h8, 3, 4'h2, 6'b000100);
    bus.flush = 1'b1;
    #1;
    n_cmp++; if (bus.wpcir !== 1'b0) begin n_err++; $display("FAIL fs_wpcir: got %b want 0", bus.wpcir); end
    exp_q.push_back('0);
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL fs_bubble: got %h want %h", got, want); end
    n_cmp++; if (bus.flush_cnt !== 4'd1) begin n_err++; $display("FAIL fs_flush_cnt: got %0d want 1", bus.flush_cnt); end
    n_cmp++; if (bus.stall_cnt !== 4'd1) begin n_err++; $display("FAIL fs_stall_cnt: got %0d want 1", bus.stall_cnt); end
    bus.flush = 1'b0;
    $display("test_flush_stall done");
  endtask

  task automatic test_saturation();
    logic [3:0] exp_c;
    // back-to-back flushes of an ordinary instruction
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    set_id(1, 2, 1, 1, 32'h5, 32'h6, 32'h7, 32'h8, 3, 4'h2, 6'b000100);
    bus.flush = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('0);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL sat_flush_bubble[%0d]: got %h want %h", i, got, want); end
      exp_c = (i + 2 > 15) ? 4'hF : 4'(i + 2);
      n_cmp++;
      if (bus.flush_cnt !== exp_c) begin n_err++; $display("FAIL sat_flush_cnt[%0d]: got %0d want %0d", i, bus.flush_cnt, exp_c); end
    end
    bus.flush = 1'b0;
    // alternating load / dependent instruction
    for (int i = 0; i < 16; i++) begin
      set_fwd(0, 0, 0, 0, 0, 0, 0);
      set_id(0, 0, 0, 0, 32'(i), 0, 0, 0, 8, 4'h0, 6'b000110);
      exp_q.push_back(mk(32'(i), 0, 0, 0, 4'h0, 8, 6'b000110));
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL sat_load[%0d]: got %h want %h", i, got, want); end
      set_fwd(8, 0, 0, 0, 0, 0, 0);
      set_id(8, 0, 1, 0, 32'h1, 0, 0, 0, 4, 4'h0, 6'b000100);
      exp_q.push_back('0);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL sat_stall_bubble[%0d]: got %h want %h", i, got, want); end
      exp_c = (i + 2 > 15) ? 4'hF : 4'(i + 2);
      n_cmp++;
      if (bus.stall_cnt !== exp_c) begin n_err++; $display("FAIL sat_stall_cnt[%0d]: got %0d want %0d", i, bus.stall_cnt, exp_c); end
    end
    n_cmp++;
    if (bus.flush_cnt !== 4'hF) begin n_err++; $display("FAIL sat_flush_hold: got %0d want 15", bus.flush_cnt); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_exe_fwd();
    test_mem_fwd();
    test_load_use();
    test_no_false_stall();
    test_flush_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
